// File: rtl/tropical_pkg.sv
// Shared definitions for the tropical ALU instruction format: operations,
// function codes, field positions and loader state encoding.
package tropical_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'd0,
    OP_OR   = 2'd1,
    OP_TADD = 2'd2,
    OP_TMUL = 2'd3
  } op_e;

  localparam logic [5:0]  FUNC_AND  = 6'd0;
  localparam logic [5:0]  FUNC_OR   = 6'd1;
  localparam logic [5:0]  FUNC_TADD = 6'd2;
  localparam logic [5:0]  FUNC_TMUL = 6'd4;
  localparam logic [5:0]  OPCODE_R  = 6'b0;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

  localparam int OPCODE_LSB = 26;
  localparam int RS_LSB     = 21;
  localparam int RT_LSB     = 16;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNC_LSB   = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PAD  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // TMUL deliberately skips func 3, which the ALU decoder treats as reserved.
  function automatic logic [5:0] op_to_func(input op_e op);
    logic [5:0] func;
    case (op)
      OP_AND:  func = FUNC_AND;
      OP_OR:   func = FUNC_OR;
      OP_TADD: func = FUNC_TADD;
      OP_TMUL: func = FUNC_TMUL;
      default: func = FUNC_AND;
    endcase
    return func;
  endfunction

endpackage

// File: rtl/tropical_instr_encoder.sv
// Combinational R-type encoder: (op, rs, rt, rd) -> 32-bit instruction word.
module tropical_instr_encoder
  import tropical_pkg::*;
(
  input  op_e         op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  output logic [31:0] word
);

  always_comb begin
    word = (32'(OPCODE_R) << OPCODE_LSB)
         | (32'(rs) << RS_LSB)
         | (32'(rt) << RT_LSB)
         | (32'(rd) << RD_LSB)
         | (32'(op_to_func(op)) << FUNC_LSB);
  end

endmodule

// File: rtl/tropical_program_loader.sv
// Instruction-memory writer: encodes handshaked requests, pads with NOPs, reports done.
// state | meaning: IDLE wait start | LOAD accept requests | PAD write NOP words | DONE image complete
module tropical_program_loader
  import tropical_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              start,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_rd,
  input  logic              req_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   prog_len,
  output logic              done
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_C  = DEPTH_C - 1'b1;

  state_e            state, state_nx;
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   count_inc;
  logic [31:0]       enc_word;
  logic              hs;

  assign count_inc = count + 1'b1;
  assign hs        = req_valid & req_ready;

  tropical_instr_encoder u_enc (
    .op   (op_e'(req_op)),
    .rs   (req_rs),
    .rt   (req_rt),
    .rd   (req_rd),
    .word (enc_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (clear) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (start) state_nx = ST_LOAD;
        ST_LOAD: if (hs && (req_last || count_inc == DEPTH_C))
                   state_nx = (count_inc < DEPTH_C) ? ST_PAD : ST_DONE;
        ST_PAD:  if (count >= LAST_C) state_nx = ST_DONE;
        ST_DONE: state_nx = ST_DONE;
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // done waits until the final registered write has been presented.
  always_comb begin
    req_ready = (state == ST_LOAD) && !clear;
    done      = (state == ST_DONE) && !imem_we;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= '0;
      prog_len   <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      imem_we <= 1'b0;
      if (clear) begin
        count    <= '0;
        prog_len <= '0;
      end else begin
        case (state)
          ST_LOAD: if (hs) begin
            imem_we    <= 1'b1;
            imem_addr  <= count[ADDR_W-1:0];
            imem_wdata <= enc_word;
            count      <= count_inc;
            if (state_nx != ST_LOAD) prog_len <= count_inc;
          end
          ST_PAD: if (count < DEPTH_C) begin
            imem_we    <= 1'b1;
            imem_addr  <= count[ADDR_W-1:0];
            imem_wdata <= NOP_WORD;
            count      <= count_inc;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tropical_program_loader.sv
// Bench for tropical_program_loader: directed and random programs checked
// against an instruction-image model built from the encoding rules.
module tb_tropical_program_loader;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              rst, clear, start, req_valid, req_last;
  logic [1:0]        req_op;
  logic [4:0]        req_rs, req_rt, req_rd;
  logic              req_ready, imem_we, done;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   prog_len;

  tropical_program_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .clear(clear), .start(start),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_last(req_last),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .prog_len(prog_len), .done(done)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_cyc_q[$];

  int          p_n;
  logic [1:0]  p_op[DEPTH];
  logic [4:0]  p_rs[DEPTH], p_rt[DEPTH], p_rd[DEPTH];
  logic        p_last[DEPTH];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_addr_q.push_back(int'(imem_addr));
      wr_data_q.push_back(imem_wdata);
      wr_cyc_q.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: R-type word from the field layout and op->func table.
  function automatic logic [31:0] model_word(input int i);
    int func;
    func = (p_op[i] == 2'd3) ? 4 : int'(p_op[i]);
    return 32'(int'(p_rs[i]) * (2 ** 21) + int'(p_rt[i]) * (2 ** 16)
               + int'(p_rd[i]) * (2 ** 11) + func);
  endfunction

  function automatic int model_len();
    for (int i = 0; i < p_n; i++) if (p_last[i]) return i + 1;
    return DEPTH;
  endfunction

  task automatic set_req(input int i);
    req_op = p_op[i]; req_rs = p_rs[i]; req_rt = p_rt[i]; req_rd = p_rd[i];
    req_last = p_last[i];
  endtask

  task automatic set_junk();
    req_op = 2'($urandom); req_rs = 5'($urandom); req_rt = 5'($urandom);
    req_rd = 5'($urandom); req_last = 1'($urandom);
  endtask

  task automatic clear_log();
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
  endtask

  task automatic issue_program(input bit gaps, input bit hold_valid, output int hs_first);
    int b;
    clear_log();
    hs_first = -1;
    req_valid = 1'b1;
    set_junk();
    repeat (2) begin
      step();
      chk("idle_ready", req_ready, 0);
    end
    chk("idle_no_write", wr_addr_q.size(), 0);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < p_n; i++) begin
      if (gaps) begin
        req_valid = 1'b0;
        repeat ($urandom_range(0, 2)) step();
      end
      set_req(i);
      req_valid = 1'b1;
      b = 0;
      while (req_ready !== 1'b1 && b < 20) begin
        step();
        b++;
      end
      if (b >= 20) chk("ready_timeout", req_ready, 1);
      step();
      if (i == 0) hs_first = cyc;
    end
    if (hold_valid) set_junk();
    else req_valid = 1'b0;
  endtask

  task automatic check_image(input int hs_first, input bit no_gaps);
    int b, exp_len, n;
    exp_len = model_len();
    b = 0;
    while (done !== 1'b1 && b < 40) begin
      step();
      b++;
    end
    chk("done_seen", done, 1);
    n = wr_addr_q.size();
    chk("write_count", n, DEPTH);
    for (int i = 0; i < n && i < DEPTH; i++) begin
      chk($sformatf("addr[%0d]", i), wr_addr_q[i], i);
      chk($sformatf("data[%0d]", i), wr_data_q[i], (i < exp_len) ? model_word(i) : 32'h0);
      if (i > 0 && (no_gaps || i >= exp_len))
        chk($sformatf("consecutive[%0d]", i), wr_cyc_q[i] - wr_cyc_q[i-1], 1);
    end
    if (n > 0) begin
      chk("first_latency", wr_cyc_q[0], hs_first);
      chk("done_timing", cyc, wr_cyc_q[n-1] + 1);
    end
    chk("prog_len", prog_len, exp_len);
    chk("done_ready", req_ready, 0);
    chk("done_we", imem_we, 0);
    req_valid = 1'b1;
    set_junk();
    repeat (3) step();
    chk("done_hold", done, 1);
    chk("no_extra_write", wr_addr_q.size(), n);
    clear = 1'b1;
    #1 chk("clear_ready", req_ready, 0);
    step();
    clear = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("clear_done", done, 0);
    chk("clear_prog_len", prog_len, 0);
    chk("clear_idle_ready", req_ready, 0);
  endtask

  task automatic set_prog(input int i, input int op, input int rs, input int rt,
                          input int rd, input bit last);
    p_op[i] = 2'(op); p_rs[i] = 5'(rs); p_rt[i] = 5'(rt); p_rd[i] = 5'(rd);
    p_last[i] = last;
  endtask

  task automatic random_prog();
    p_n = $urandom_range(1, DEPTH);
    for (int i = 0; i < p_n; i++)
      set_prog(i, $urandom_range(0, 3), $urandom_range(0, 31), $urandom_range(0, 31),
               $urandom_range(0, 31), 1'b0);
    if (!(p_n == DEPTH && $urandom_range(0, 1) == 1)) p_last[p_n-1] = 1'b1;
  endtask

  initial begin
    int hs, b, n;
    rst = 1'b1; clear = 1'b0; start = 1'b0; req_valid = 1'b0;
    req_op = '0; req_rs = '0; req_rt = '0; req_rd = '0; req_last = 1'b0;
    #12;
    chk("rst_we", imem_we, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_prog_len", prog_len, 0);
    chk("rst_wdata", imem_wdata, 0);
    @(negedge clk) rst = 1'b0;
    step();

    // Single TADD with last: one user word then seven pads.
    p_n = 1;
    set_prog(0, 2, 3, 4, 0, 1'b1);
    issue_program(1'b0, 1'b0, hs);
    check_image(hs, 1'b1);

    // Five back-to-back requests, the last flagged.
    p_n = 5;
    set_prog(0, 0, 1, 2, 0, 1'b0);
    set_prog(1, 1, 1, 2, 0, 1'b0);
    set_prog(2, 2, 3, 4, 0, 1'b0);
    set_prog(3, 3, 3, 4, 0, 1'b0);
    set_prog(4, 2, 1, 2, 0, 1'b1);
    issue_program(1'b0, 1'b1, hs);
    check_image(hs, 1'b1);

    // Full memory without last: LOAD goes straight to DONE.
    p_n = DEPTH;
    for (int i = 0; i < DEPTH; i++)
      set_prog(i, i % 4, $urandom_range(0, 31), $urandom_range(0, 31), i, 1'b0);
    issue_program(1'b0, 1'b1, hs);
    check_image(hs, 1'b1);

    // Clear while the pad word at address 3 is on the bus.
    p_n = 2;
    set_prog(0, 1, 5, 6, 7, 1'b0);
    set_prog(1, 3, 8, 9, 10, 1'b1);
    issue_program(1'b0, 1'b0, hs);
    b = 0;
    while (!(imem_we === 1'b1 && imem_addr === 3'd3) && b < 20) begin
      step();
      b++;
    end
    chk("pad3_reached", imem_addr, 3);
    clear = 1'b1;
    #1 chk("clear_pad_ready", req_ready, 0);
    step();
    clear = 1'b0;
    #1;
    chk("clear_pad_done", done, 0);
    chk("clear_pad_prog_len", prog_len, 0);
    repeat (3) step();
    chk("clear_pad_we", imem_we, 0);
    chk("clear_pad_writes", wr_addr_q.size(), 4);
    n = wr_addr_q.size();
    if (n > 0) chk("clear_pad_last_addr", wr_addr_q[n-1], 3);

    // Reload after clear must restart at address 0.
    random_prog();
    issue_program(1'b1, 1'b0, hs);
    check_image(hs, 1'b0);

    // Asynchronous reset between edges while a user write is on the bus.
    clear_log();
    start = 1'b1;
    step();
    start = 1'b0;
    p_n = 1;
    set_prog(0, 1, 2, 3, 4, 1'b0);
    set_req(0);
    req_valid = 1'b1;
    step();
    chk("pre_rst_we", imem_we, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_we", imem_we, 0);
    chk("async_rst_ready", req_ready, 0);
    chk("async_rst_done", done, 0);
    #2 rst = 1'b0;
    clear_log();
    repeat (2) step();
    chk("post_rst_idle_ready", req_ready, 0);
    chk("post_rst_no_write", wr_addr_q.size(), 0);
    req_valid = 1'b0;

    // Random programs, with and without valid gaps.
    for (int k = 0; k < 8; k++) begin
      bit g;
      g = 1'($urandom_range(0, 1));
      random_prog();
      issue_program(g, 1'($urandom_range(0, 1)), hs);
      check_image(hs, !g);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
